sdram_capture_writer: RTL
=========================

Name: sdram_capture_writer

Overview:
- Write-side client of the SDRAM controller user port. It captures a stream of 16-bit ADC samples into a small FIFO and drains the FIFO as single-word write requests (Req/WnR/Address/Data in, Ack/Busy out of the controller).
- Writes a contiguous block of Length words starting at BaseAddr, then flags Done.
- Sits between the ADC sample front-end and the SDRAM controller.

Parameters:
FIFO_DEPTH, 16, sample buffer depth in words; power of 2, minimum 4
ACK_TIMEOUT, 1024, max cycles in REQ waiting for Ack before abort

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
Sample  in  16  ADC sample word
SampleValid  in  1  Sample valid this cycle
Start  in  1  single-cycle pulse, begins a capture
BaseAddr  in  22  first SDRAM word address, latched on Start
Length  in  22  words to capture, latched on Start
Active  out  1  capture in progress
Done  out  1  capture finished (sticky until next Start or Reset)
Overflow  out  1  sticky: a sample was dropped because the FIFO was full
Timeout  out  1  sticky: Ack not received within ACK_TIMEOUT
WordsWritten  out  22  count of acknowledged writes in the current capture
Req  out  1  request to controller
WnR  out  1  write-not-read; tied 1
Address  out  22  SDRAM word address of request
Data  out  16  write data of request
Ack  in  1  controller acknowledgement
Busy  in  1  controller not idle (refresh or command in progress)

Behaviour:
- Reset values: Req=0, WnR=1, Address=0, Data=0, Active=0, Done=0, Overflow=0, Timeout=0, WordsWritten=0. FIFO empty, push count 0, state IDLE.
- Reset mid-capture: all values return to reset in one edge. Req drops at that edge. The in-flight write is abandoned.
- States: IDLE, RUN, REQ, DONE.
- IDLE / DONE, on Start:
  - Latch BaseAddr and Length.
  - Clear Done, Overflow, Timeout, WordsWritten, push count. Flush the FIFO.
  - Set Active=1 and go to RUN.
  - If the latched Length is 0: go to DONE next cycle with Done=1, Active=0, and no requests.
- Start is ignored in RUN and REQ.
- Push path (Active only): on SampleValid with push count < Length:
  - FIFO not full: write Sample, increment push count.
  - FIFO full: drop the sample and set Overflow=1. Push count does not advance.
  - Full is the registered occupancy before the edge. A same-cycle pop does not allow the push.
  - Push and pop in the same cycle are otherwise legal.
  - SampleValid is ignored when push count == Length or Active=0.
- RUN: if FIFO not empty, Busy=0 and Ack=0:
  - Pop the head into Data.
  - Set Address = (base + WordsWritten) mod 2^22 (22-bit wrap, no error).
  - Set Req=1, go to REQ, clear the timeout counter.
- REQ:
  - Hold Req, Address and Data stable until Ack=1.
  - On the edge where Ack=1 is sampled: Req<=0 and WordsWritten++. Go to DONE if the new WordsWritten == Length, else RUN.
  - The Ack=0 check in RUN guarantees the controller's stale Ack from the previous write is never counted.
  - Timeout counter increments each REQ cycle without Ack. On reaching ACK_TIMEOUT: Req<=0, Timeout=1, Active=0, go to DONE, Done=1.
- DONE: Done=1, Active=0, Req=0. Remaining FIFO contents are discarded on the next Start.
- Throughput: at most one write per 4 cycles against the controller (Req edge, Ack seen, controller return to idle, Ack clear). No sample loss when the sample rate is 1 per 4 cycles or slower and no refresh occurs.
- An Ack that arrives outside REQ is ignored.

Test Plan:
- Basic capture:
  - Stimulus: BaseAddr=0x000100, Length=8, 8 samples 0xA000..0xA007 at 1 per 8 cycles, controller model with fixed 1-cycle Ack.
  - Required: 8 writes, Address 0x100..0x107 with matching Data, Req high only until Ack is seen, Done=1, WordsWritten=8, Overflow=0.
- Address wrap:
  - Stimulus: BaseAddr=0x3FFFFE, Length=4.
  - Required: Addresses 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001.
- Busy stall / refresh:
  - Stimulus: hold Busy=1 for 40 cycles while 20 samples arrive back-to-back, FIFO_DEPTH=16.
  - Required: no Req during Busy, exactly 16 words written with the first 16 sample values, Overflow=1. Length=20 never completes, so Done stays 0.
- Timeout:
  - Stimulus: controller never asserts Ack.
  - Required: Req drops after exactly 1024 REQ cycles, Timeout=1, Done=1, Active=0, WordsWritten=0.
- Length=0 and Start during RUN:
  - Stimulus (a): Start with Length=0. Required: Done=1 next cycle, no Req.
  - Stimulus (b): a second Start pulse mid-capture. Required: ignored, original capture completes unchanged.
- Reset mid-REQ:
  - Stimulus: assert Reset while Req=1.
  - Required: next cycle all outputs at reset values, and a fresh Start captures correctly from the new BaseAddr.

Source files
------------

// File: rtl/sdram_capture_writer.sv
// ADC capture writer: buffers 16-bit samples in a small FIFO and drains them as
// single-word SDRAM write requests over a Req/Ack user port, covering one block.
module sdram_capture_writer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Sample,
  input  logic        SampleValid,
  input  logic        Start,
  input  logic [21:0] BaseAddr,
  input  logic [21:0] Length,
  output logic        Active,
  output logic        Done,
  output logic        Overflow,
  output logic        Timeout,
  output logic [21:0] WordsWritten,
  output logic        Req,
  output logic        WnR,
  output logic [21:0] Address,
  output logic [15:0] Data,
  input  logic        Ack,
  input  logic        Busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LIMIT = TW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REQ, S_DONE} state_t;

  state_t        state_q;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic [21:0]   base_q, len_q, push_cnt_q, words_q, addr_q;
  logic [15:0]   data_q;
  logic          req_q, active_q, done_q, ovf_q, to_q;
  logic [TW-1:0] tcnt_q;

  logic          start_ok, full, empty, want_push, do_push, do_pop;
  logic [21:0]   words_d;
  logic [TW-1:0] tcnt_d;

  assign start_ok  = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign want_push = active_q && SampleValid && (push_cnt_q < len_q);
  assign do_push   = want_push && !full;
  // Ack must be low before a new request so the previous write's Ack is never recounted.
  assign do_pop    = (state_q == S_RUN) && (len_q != '0) && !empty && !Busy && !Ack;
  assign words_d   = words_q + 22'd1;
  assign tcnt_d    = tcnt_q + 1'b1;

  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wp_q] <= Sample;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      len_q      <= '0;
      push_cnt_q <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      to_q       <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      if (do_push) begin
        wp_q       <= wp_q + 1'b1;
        push_cnt_q <= push_cnt_q + 22'd1;
      end else if (want_push) begin
        ovf_q <= 1'b1;
      end
      if (do_pop) rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            base_q     <= BaseAddr;
            len_q      <= Length;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            to_q       <= 1'b0;
            words_q    <= '0;
            push_cnt_q <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            active_q   <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (len_q == '0) begin
            active_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (do_pop) begin
            data_q  <= mem_q[rp_q];
            addr_q  <= base_q + words_q;
            req_q   <= 1'b1;
            tcnt_q  <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (Ack) begin
            req_q   <= 1'b0;
            words_q <= words_d;
            if (words_d == len_q) begin
              active_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_RUN;
            end
          end else if (tcnt_d == TO_LIMIT) begin
            req_q    <= 1'b0;
            to_q     <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            tcnt_q <= tcnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Active       = active_q;
  assign Done         = done_q;
  assign Overflow     = ovf_q;
  assign Timeout      = to_q;
  assign WordsWritten = words_q;
  assign Req          = req_q;
  assign WnR          = 1'b1;
  assign Address      = addr_q;
  assign Data         = data_q;

endmodule
